// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting controller: state encoding,
// edit-select codes, time field width and the wrap-around increment helper.
package time_set_pkg;

    localparam int TIME_W = 7;

    localparam logic [1:0] SEL_RUN  = 2'b00;
    localparam logic [1:0] SEL_HRS  = 2'b01;
    localparam logic [1:0] SEL_MINS = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    // State codes double as the editSel_o value so the output is the state itself.
    typedef enum logic [1:0] {
        ST_RUN      = SEL_RUN,
        ST_SET_HRS  = SEL_HRS,
        ST_SET_MINS = SEL_MINS,
        ST_LOAD     = SEL_LOAD
    } state_t;

    // Values at or above the terminal count wrap to zero, so an out-of-range
    // captured time cannot walk upward forever.
    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] val,
                                                   input logic [TIME_W-1:0] tc);
        return (val >= tc) ? '0 : val + TIME_W'(1);
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button/time/load bundle between the clock datapath (master) and the
// time-setting controller (slave).
interface time_set_ctrl_if;

    logic                             modeBtn_i;
    logic                             upBtn_i;
    logic [time_set_pkg::TIME_W-1:0]  hrs_i;
    logic [time_set_pkg::TIME_W-1:0]  mins_i;
    logic                             nLoadNow_o;
    logic [time_set_pkg::TIME_W-1:0]  loadHrs_o;
    logic [time_set_pkg::TIME_W-1:0]  loadMins_o;
    logic [1:0]                       editSel_o;

    modport master (
        output modeBtn_i, upBtn_i, hrs_i, mins_i,
        input  nLoadNow_o, loadHrs_o, loadMins_o, editSel_o
    );

    modport slave (
        input  modeBtn_i, upBtn_i, hrs_i, mins_i,
        output nLoadNow_o, loadHrs_o, loadMins_o, editSel_o
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-time debouncer and one-cycle press pulse.
// The debounced level is exported only when TIME_SET_AUTOREPEAT_EN is defined.
module btn_debounce #(
    parameter int unsigned DBNC_TC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
`ifdef TIME_SET_AUTOREPEAT_EN
    output logic level,
`endif
    output logic press
);

    localparam int CW = (DBNC_TC > 0) ? $clog2(DBNC_TC + 1) : 1;

    logic          sync_1;
    logic          sync_2;
    logic          db_q;
    logic          armed;
    logic [CW-1:0] cnt;

    // armed stays low after reset until the input has been seen stably low, so a
    // button held through reset release yields no press until pressed again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            db_q   <= 1'b0;
            armed  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 != db_q) begin
                if (cnt == CW'(DBNC_TC)) begin
                    db_q  <= sync_2;
                    cnt   <= '0;
                    press <= sync_2 & armed;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (!armed && !db_q) begin
                if (cnt == CW'(DBNC_TC)) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

`ifdef TIME_SET_AUTOREPEAT_EN
    assign level = db_q;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/up button time-setting controller: RUN -> SET_HRS -> SET_MINS -> LOAD.
// Define TIME_SET_AUTOREPEAT_EN to enable hold-to-repeat on the up button.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int unsigned hrs_tc_p   = 11,
    parameter int unsigned mins_tc_p  = 59,
    parameter int unsigned dbnc_tc_p  = 999999,
    parameter int unsigned rpt_dly_p  = 24999999,
    parameter int unsigned rpt_rate_p = 9999999
) (
    input  logic               clk_i,
    input  logic               rst_i,
    time_set_ctrl_if.slave     bus
);

    localparam logic [TIME_W-1:0] HRS_TC  = TIME_W'(hrs_tc_p);
    localparam logic [TIME_W-1:0] MINS_TC = TIME_W'(mins_tc_p);

    state_t            state;
    logic [TIME_W-1:0] edit_hrs;
    logic [TIME_W-1:0] edit_mins;
    logic              n_load;
    logic              mode_press;
    logic              up_press;
    logic              up_step;

`ifdef TIME_SET_AUTOREPEAT_EN
    logic mode_level;
    logic up_level;
`endif

    btn_debounce #(.DBNC_TC(dbnc_tc_p)) u_mode_db (
        .clk   (clk_i),
        .rst   (rst_i),
        .btn   (bus.modeBtn_i),
`ifdef TIME_SET_AUTOREPEAT_EN
        .level (mode_level),
`endif
        .press (mode_press)
    );

    btn_debounce #(.DBNC_TC(dbnc_tc_p)) u_up_db (
        .clk   (clk_i),
        .rst   (rst_i),
        .btn   (bus.upBtn_i),
`ifdef TIME_SET_AUTOREPEAT_EN
        .level (up_level),
`endif
        .press (up_press)
    );

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (rpt_dly_p > rpt_rate_p) ? rpt_dly_p : rpt_rate_p;
    localparam int          RPT_CW  = (RPT_MAX > 0) ? $clog2(RPT_MAX + 1) : 1;

    logic              editing;
    logic              rpt_first;
    logic              rpt_hit;
    logic [RPT_CW-1:0] rpt_cnt;

    assign editing = (state == ST_SET_HRS) || (state == ST_SET_MINS);
    assign rpt_hit = rpt_first ? (rpt_cnt == RPT_CW'(rpt_rate_p))
                               : (rpt_cnt == RPT_CW'(rpt_dly_p));
    assign up_step = up_press | (editing & up_level & ~mode_press & rpt_hit);

    // Any press restarts the hold timer; a mode press is the only way the edit
    // state changes outside reset, so it covers the state-change restart too.
    always_ff @(posedge clk_i) begin
        if (rst_i || !editing || !up_level || up_press || mode_press) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (rpt_hit) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_CW'(1);
        end
    end
`else
    assign up_step = up_press;
`endif

    // Mode is tested before up in every state, so a simultaneous up press is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_RUN;
            edit_hrs  <= '0;
            edit_mins <= '0;
            n_load    <= 1'b1;
        end else begin
            n_load <= 1'b1;
            case (state)
                ST_RUN: begin
                    if (mode_press) begin
                        state     <= ST_SET_HRS;
                        edit_hrs  <= bus.hrs_i;
                        edit_mins <= bus.mins_i;
                    end
                end
                ST_SET_HRS: begin
                    if (mode_press) begin
                        state <= ST_SET_MINS;
                    end else if (up_step) begin
                        edit_hrs <= wrap_inc(edit_hrs, HRS_TC);
                    end
                end
                ST_SET_MINS: begin
                    if (mode_press) begin
                        state  <= ST_LOAD;
                        n_load <= 1'b0;
                    end else if (up_step) begin
                        edit_mins <= wrap_inc(edit_mins, MINS_TC);
                    end
                end
                ST_LOAD: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.nLoadNow_o = n_load;
    assign bus.loadHrs_o  = edit_hrs;
    assign bus.loadMins_o = edit_mins;
    assign bus.editSel_o  = state;

endmodule
